pc_return_stack: RTL and testbench

//   Hardware LIFO that saves and restores program-counter values for call/return
//   and context-exchange flows. The control path pushes the return PC on a call or

---
 rtl/pc_return_stack.sv | 136 +++++++++++++
 tb/tb_pc_return_stack.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_return_stack.sv
// pc_return_stack: hardware LIFO of program-counter values for call/return and
// context-exchange flows. Popped values are presented registered with a 1-cycle
// valid strobe. Sticky overflow/underflow flags are cleared by clearErr.
// Optional feature macro: RSTACK_WRAP_EN (push while full overwrites the oldest
// entry instead of being dropped).
module pc_return_stack #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clock,
    input  logic              resetCPU_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushAddress,
    input  logic              pop,
    input  logic              clearErr,
    output logic [ADDR_W-1:0] returnAddress,
    output logic              returnValid,
    output logic [ADDR_W-1:0] topAddress,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned COUNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  mem [DEPTH];

    logic [PTR_W-1:0]   top_q, top_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0]  ret_q, ret_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    logic               mem_we;
    logic [PTR_W-1:0]   mem_widx;
    logic               new_ovf;
    logic               new_udf;

    // Status and lookahead derived from registered state only
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == COUNT_W'(DEPTH));
        topAddress = empty ? '0 : mem[top_q];
    end

    // Next-state decode for pointer, count, return register and error flags
    always_comb begin
        top_d    = top_q;
        count_d  = count_q;
        ret_d    = ret_q;
        valid_d  = 1'b0;
        mem_we   = 1'b0;
        mem_widx = top_q + PTR_W'(1);
        new_ovf  = 1'b0;
        new_udf  = 1'b0;

        unique case ({push, pop})
            2'b11: begin
                valid_d = 1'b1;
                if (empty) begin
                    // Bypass: the pushed value is returned straight away
                    ret_d = pushAddress;
                end else begin
                    // Exchange the top entry in place
                    ret_d    = mem[top_q];
                    mem_we   = 1'b1;
                    mem_widx = top_q;
                end
            end
            2'b01: begin
                if (empty) begin
                    new_udf = 1'b1;
                end else begin
                    ret_d   = mem[top_q];
                    valid_d = 1'b1;
                    top_d   = top_q - PTR_W'(1);
                    count_d = count_q - COUNT_W'(1);
                end
            end
            2'b10: begin
                if (!full) begin
                    mem_we  = 1'b1;
                    top_d   = top_q + PTR_W'(1);
                    count_d = count_q + COUNT_W'(1);
                end else begin
                    new_ovf = 1'b1;
`ifdef RSTACK_WRAP_EN
                    // Oldest entry sits at top+1 when full; overwrite it
                    mem_we  = 1'b1;
                    top_d   = top_q + PTR_W'(1);
`endif
                end
            end
            default: ;
        endcase

        // A fresh error in the clearing cycle keeps the flag set
        ovf_d = (ovf_q & ~clearErr) | new_ovf;
        udf_d = (udf_q & ~clearErr) | new_udf;
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clock or negedge resetCPU_n) begin
        if (!resetCPU_n) begin
            top_q   <= '0;
            count_q <= '0;
            ret_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ret_q   <= ret_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array write port; contents are intentionally not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_widx] <= pushAddress;
        end
    end

    assign returnAddress = ret_q;
    assign returnValid   = valid_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// Self-checking bench for pc_return_stack: a queue-based stack model predicts
// each return value into a scoreboard that is drained when returnValid fires.
module tb_pc_return_stack;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;

    logic              clock;
    logic              resetCPU_n;
    logic              push;
    logic [ADDR_W-1:0] pushAddress;
    logic              pop;
    logic              clearErr;
    logic [ADDR_W-1:0] returnAddress;
    logic              returnValid;
    logic [ADDR_W-1:0] topAddress;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [ADDR_W-1:0] stk[$];
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] m_ret;
    logic              m_ovf;
    logic              m_udf;
    logic              m_valid;

    pc_return_stack #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .resetCPU_n   (resetCPU_n),
        .push         (push),
        .pushAddress  (pushAddress),
        .pop          (pop),
        .clearErr     (clearErr),
        .returnAddress(returnAddress),
        .returnValid  (returnValid),
        .topAddress   (topAddress),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        exp_q.delete();
        m_ret   = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_valid = 1'b0;
    endtask

    // Compare all outputs against the model; drain scoreboard on a strobe
    task automatic check_all(input string tag);
        logic [ADDR_W-1:0] e;
        chk({tag, ".valid"}, 32'(returnValid), 32'(m_valid));
        if (returnValid) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_nonempty"}, 32'(0), 32'(1));
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".ret"}, 32'(returnAddress), 32'(e));
            end
        end
        chk({tag, ".ret_hold"}, 32'(returnAddress), 32'(m_ret));
        chk({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(stk.size() == DEPTH));
        chk({tag, ".top"}, 32'(topAddress), (stk.size() == 0) ? 32'(0) : 32'(stk[$]));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    endtask

    // One clock cycle of stimulus: update model, drive, clock, check
    task automatic step(input string tag, input logic p, input logic [ADDR_W-1:0] a,
                        input logic q, input logic c);
        logic no = 1'b0;
        logic nu = 1'b0;
        m_valid = 1'b0;
        if (p && q) begin
            m_valid = 1'b1;
            if (stk.size() == 0) begin
                m_ret = a;
            end else begin
                m_ret = stk[$];
                stk[$] = a;
            end
            exp_q.push_back(m_ret);
        end else if (q) begin
            if (stk.size() == 0) begin
                nu = 1'b1;
            end else begin
                m_ret = stk.pop_back();
                m_valid = 1'b1;
                exp_q.push_back(m_ret);
            end
        end else if (p) begin
            if (stk.size() == DEPTH) begin
                no = 1'b1;
`ifdef RSTACK_WRAP_EN
                void'(stk.pop_front());
                stk.push_back(a);
`endif
            end else begin
                stk.push_back(a);
            end
        end
        m_ovf = (m_ovf & ~c) | no;
        m_udf = (m_udf & ~c) | nu;

        push        = p;
        pushAddress = a;
        pop         = q;
        clearErr    = c;
        @(posedge clock);
        #1;
        push     = 1'b0;
        pop      = 1'b0;
        clearErr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        push        = 1'b0;
        pushAddress = '0;
        pop         = 1'b0;
        clearErr    = 1'b0;
        resetCPU_n  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset_held");
        resetCPU_n = 1'b1;
        @(posedge clock);
        #1;
        check_all("reset_rel");

        // Basic push/pop ordering
        step("push100", 1'b1, 12'h100, 1'b0, 1'b0);
        step("push101", 1'b1, 12'h101, 1'b0, 1'b0);
        step("push43B", 1'b1, 12'h43B, 1'b0, 1'b0);
        step("pop1", 1'b0, '0, 1'b1, 1'b0);
        step("pop2", 1'b0, '0, 1'b1, 1'b0);
        step("pop3", 1'b0, '0, 1'b1, 1'b0);
        step("idle1", 1'b0, '0, 1'b0, 1'b0);

        // Underflow, held return value, then clear
        step("udf_pop", 1'b0, '0, 1'b1, 1'b0);
        step("udf_idle", 1'b0, '0, 1'b0, 1'b0);
        step("udf_clr", 1'b0, '0, 1'b0, 1'b1);

        // Fill to DEPTH and overflow
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1'b1, 12'(i), 1'b0, 1'b0);
        end
        step("ovf_push", 1'b1, 12'(DEPTH + 1), 1'b0, 1'b0);
        // Clear and new error in the same cycle: error wins
        step("ovf_clr_win", 1'b1, 12'h0AA, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1, 1'b0);
        end
        step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);

        // Exchange at top, and bypass when empty
        step("push200", 1'b1, 12'h200, 1'b0, 1'b0);
        step("xchg300", 1'b1, 12'h300, 1'b1, 1'b0);
        step("pop300", 1'b0, '0, 1'b1, 1'b0);
        step("bypass0FF", 1'b1, 12'h0FF, 1'b1, 1'b0);
        step("idle2", 1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset between clock edges drops everything immediately
        step("r_push1", 1'b1, 12'h011, 1'b0, 1'b0);
        step("r_push2", 1'b1, 12'h022, 1'b0, 1'b0);
        step("r_push3", 1'b1, 12'h033, 1'b1, 1'b0);
        step("r_push4", 1'b1, 12'h044, 1'b0, 1'b0);
        #2;
        resetCPU_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        resetCPU_n = 1'b1;
        @(posedge clock);
        #1;
        check_all("after_rst");
        step("rst_udf", 1'b0, '0, 1'b1, 1'b0);
        step("final_idle", 1'b0, '0, 1'b0, 1'b0);

        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
